div_sequencer: RTL

Multi-cycle controller for the M-extension divide/remainder operations (DIV, DIVU, REM, REMU) in the RV32IM execute stage. It decodes the 5-bit EX-stage ALU control code, runs a 32-step radix-2 restoring division, stalls the front of the pipeline while busy, and presents a one-cycle-valid result. The EX result mux selects DivResultE whenever DivDoneE is high. MUL-family and base ops bypass this block.

---
 rtl/div_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring divider controller for the
// RV32M DIV/DIVU/REM/REMU ops in EX. Holds the front of the pipeline while
// iterating and presents a one-cycle-valid result (extended by StallE).
module div_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ValidE,
  input  logic [4:0]  ALUControlE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        FlushE,
  input  logic        StallE,
  output logic        StallDiv,
  output logic        DivDoneE,
  output logic [31:0] DivResultE
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [4:0] OP_DIV  = 5'b10001;
  localparam logic [4:0] OP_DIVU = 5'b10101;
  localparam logic [4:0] OP_REM  = 5'b11001;
  localparam logic [4:0] OP_REMU = 5'b11101;

  logic [1:0]  state_q,    state_d;
  logic        op_rem_q,   op_rem_d;
  logic        neg_quo_q,  neg_quo_d;
  logic        neg_rem_q,  neg_rem_d;
  logic [31:0] divisor_q,  divisor_d;
  logic [31:0] quo_q,      quo_d;
  logic [32:0] rem_q,      rem_d;
  logic [5:0]  cnt_q,      cnt_d;
  logic [31:0] result_q,   result_d;

  logic        is_div, go, op_signed, op_rem;
  logic [31:0] abs_a, abs_b;
  logic [32:0] shifted, diff, rem_step;
  logic [31:0] quo_step, quo_fix, rem_fix;

  // Decode the EX op and derive operand magnitudes for the start cycle.
  always_comb begin
    is_div    = (ALUControlE == OP_DIV)  || (ALUControlE == OP_DIVU) ||
                (ALUControlE == OP_REM)  || (ALUControlE == OP_REMU);
    go        = ValidE & is_div & ~FlushE;
    // bit 2 distinguishes unsigned, bit 3 distinguishes remainder
    op_signed = ~ALUControlE[2];
    op_rem    = ALUControlE[3];
    abs_a     = (op_signed && SrcAE[31]) ? (32'd0 - SrcAE) : SrcAE;
    abs_b     = (op_signed && SrcBE[31]) ? (32'd0 - SrcBE) : SrcBE;
  end

  // One restoring-division step plus sign correction of its outcome.
  always_comb begin
    shifted = {rem_q[31:0], quo_q[31]};
    diff    = shifted - {1'b0, divisor_q};
    if (!diff[32]) begin
      rem_step = diff;
      quo_step = {quo_q[30:0], 1'b1};
    end else begin
      rem_step = shifted;
      quo_step = {quo_q[30:0], 1'b0};
    end
    quo_fix = neg_quo_q ? (32'd0 - quo_step)       : quo_step;
    rem_fix = neg_rem_q ? (32'd0 - rem_step[31:0]) : rem_step[31:0];
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d   = state_q;
    op_rem_d  = op_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    divisor_d = divisor_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          op_rem_d  = op_rem;
          neg_quo_d = op_signed & (SrcAE[31] ^ SrcBE[31]);
          neg_rem_d = op_signed & SrcAE[31];
          if (SrcBE == 32'd0) begin
            // divide by zero: all-ones quotient, remainder is the dividend
            result_d = op_rem ? SrcAE : 32'hFFFF_FFFF;
            state_d  = S_DONE;
          end else if (op_signed && SrcAE == 32'h8000_0000 &&
                       SrcBE == 32'hFFFF_FFFF) begin
            // signed overflow: quotient wraps to INT_MIN, remainder 0
            result_d = op_rem ? 32'd0 : 32'h8000_0000;
            state_d  = S_DONE;
          end else begin
            quo_d     = abs_a;
            divisor_d = abs_b;
            rem_d     = 33'd0;
            cnt_d     = 6'd31;
            state_d   = S_RUN;
          end
        end
      end
      S_RUN: begin
        rem_d = rem_step;
        quo_d = quo_step;
        if (cnt_q == 6'd0) begin
          result_d = op_rem_q ? rem_fix : quo_fix;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_DONE: begin
        if (!StallE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // a flush kills the instruction wherever we are; no result is written
    if (FlushE) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divisor_q <= 32'd0;
      quo_q     <= 32'd0;
      rem_q     <= 33'd0;
      cnt_q     <= 6'd0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      op_rem_q  <= op_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      divisor_q <= divisor_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  // Handshake outputs; a flush silences both in the same cycle.
  always_comb begin
    StallDiv   = rst_n & ~FlushE &
                 (((state_q == S_IDLE) & go) | (state_q == S_RUN));
    DivDoneE   = (state_q == S_DONE) & ~FlushE;
    DivResultE = result_q;
  end

endmodule
